mem_block_responder: RTL and testbench

- Memory-side responder for the 128-bit block interface driven by the cache blocks (`mem_read`/`mem_write`/`mem_addr`/`mem_wdata` in, `mem_ready`/`mem_rdata` out).
- Backs a 2^`DEPTH_LOG2`-block on-chip store with a programmable fixed access latency.
- Returns a single-cycle `mem_ready` pulse per accepted request.
- Serves as the main-memory model behind the split L1 caches and as the latency-configurable endpoint for L2 integration.

---
 rtl/mem_block_responder.sv | 127 ++++++++++++
 tb/tb_mem_block_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_block_responder.sv
// Block-memory responder for the cache-side 128-bit interface: a 2^DEPTH_LOG2-entry store
// that returns a one-cycle mem_ready pulse a fixed LATENCY cycles after it accepts a request.
module mem_block_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic         mem_ready,
  output logic [127:0] mem_rdata,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  localparam int         LAT_EFF  = (LATENCY < 1) ? 1 : LATENCY;
  localparam logic [7:0] CNT_INIT = 8'(LAT_EFF - 1);
  localparam int         DEPTH    = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, COOL} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [127:0]          wdata_q, wdata_d;
  logic                  is_wr_q, is_wr_d;
  logic [127:0]          rdata_q, rdata_d;
  logic [15:0]           rd_count_q, rd_count_d;
  logic [15:0]           wr_count_q, wr_count_d;
  logic                  go_resp;
  logic                  unused_addr;

  logic [127:0] store [DEPTH];

  // Upper address bits alias onto the store and are deliberately ignored.
  assign unused_addr = ^mem_addr;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      rdata_q    <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      rdata_q    <= rdata_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // go_resp marks the edge that enters RESP; the *_d request fields are valid on that
  // edge both when coming from BUSY and on a direct IDLE->RESP acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    go_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read | mem_write) begin
          idx_d   = mem_addr[DEPTH_LOG2-1:0];
          wdata_d = mem_wdata;
          is_wr_d = mem_write;
          cnt_d   = CNT_INIT;
          if (LAT_EFF == 1) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = RESP;
          go_resp = 1'b1;
        end
      end
      RESP:    state_d = COOL;
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d    = rdata_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (go_resp) begin
      if (is_wr_d) begin
        rdata_d = wdata_d;
        if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
      end else begin
        rdata_d = store[idx_d];
        if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
      end
    end
  end

  // NOTE: the store has no reset; gating on proc_reset keeps an aborted write from committing.
  always_ff @(posedge clk) begin
    if (go_resp && is_wr_d && !proc_reset) store[idx_d] <= wdata_d;
  end

  always_comb begin
    mem_ready = (state_q == RESP);
    mem_rdata = rdata_q;
    rd_count  = rd_count_q;
    wr_count  = wr_count_q;
  end

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench for mem_block_responder: a vector table on a LATENCY=4 instance plus
// hand sequences for aliasing, reset abort, held requests and counter saturation (LATENCY=1).
module tb_mem_block_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         a_rd, a_wr, a_ready;
  logic [27:0]  a_addr;
  logic [127:0] a_wdata, a_rdata;
  logic [15:0]  a_rdc, a_wrc;
  logic         b_rd, b_wr, b_ready;
  logic [27:0]  b_addr;
  logic [127:0] b_wdata, b_rdata;
  logic [15:0]  b_rdc, b_wrc;

  mem_block_responder #(.LATENCY(4), .DEPTH_LOG2(10)) dut_a (
    .clk(clk), .proc_reset(rst), .mem_read(a_rd), .mem_write(a_wr), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_ready(a_ready), .mem_rdata(a_rdata),
    .rd_count(a_rdc), .wr_count(a_wrc)
  );

  mem_block_responder #(.LATENCY(1), .DEPTH_LOG2(10)) dut_b (
    .clk(clk), .proc_reset(rst), .mem_read(b_rd), .mem_write(b_wr), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_ready(b_ready), .mem_rdata(b_rdata),
    .rd_count(b_rdc), .wr_count(b_wrc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
    logic [15:0]  exp_rdc;
    logic [15:0]  exp_wrc;
  } vec_t;

  localparam logic [127:0] D0  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DAA = {16{8'hAA}};
  localparam logic [127:0] D11 = {16{8'h11}};
  localparam logic [127:0] D55 = {16{8'h55}};
  localparam logic [127:0] D77 = {16{8'h77}};
  localparam logic [127:0] DC0 = {8{16'hC0FE}};
  localparam logic [127:0] DAL = {4{32'hDEADBEEF}};
  localparam logic [127:0] DXX = {4{32'h0BADF00D}};

  // Issues one request on dut_a, measures edges until mem_ready, drops the request,
  // checks the pulse is one cycle wide, then waits out COOL so the next call starts in IDLE.
  task automatic run_txn(input string name, input logic rd, input logic wr,
                         input logic [27:0] addr, input logic [127:0] wd, output int lat);
    @(negedge clk);
    a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!a_ready && lat < 50);
    a_rd = 1'b0; a_wr = 1'b0;
    @(posedge clk); #1;
    check({name, " pulse width"}, 128'(a_ready), 128'(0));
    @(posedge clk); #1;
  endtask

  vec_t vecs [7];
  int   lat;
  logic [7:0] pat;
  int   highs;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 28'h0000005, D0,  D0,  16'd0, 16'd1};
    vecs[1] = '{1'b1, 1'b0, 28'h0000005, DXX, D0,  16'd1, 16'd1};
    vecs[2] = '{1'b1, 1'b1, 28'h0000012, DAA, DAA, 16'd1, 16'd2};
    vecs[3] = '{1'b1, 1'b0, 28'h0000012, DXX, DAA, 16'd2, 16'd2};
    vecs[4] = '{1'b0, 1'b1, 28'h0000003, D11, D11, 16'd2, 16'd3};
    vecs[5] = '{1'b0, 1'b1, 28'h0000000, DC0, DC0, 16'd2, 16'd4};
    vecs[6] = '{1'b0, 1'b1, 28'h0000007, D77, D77, 16'd2, 16'd5};

    rst = 1'b1;
    a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready",  128'(a_ready), 128'(0));
    check("reset rdata",  a_rdata,       128'(0));
    check("reset rd_cnt", 128'(a_rdc),   128'(0));
    check("reset wr_cnt", 128'(a_wrc),   128'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat);
      check($sformatf("vec%0d latency", i), 128'(lat), 128'(4));
      check($sformatf("vec%0d rdata", i), a_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d rd_cnt", i), 128'(a_rdc), 128'(vecs[i].exp_rdc));
      check($sformatf("vec%0d wr_cnt", i), 128'(a_wrc), 128'(vecs[i].exp_wrc));
    end

    // Aliased write whose address and data change while BUSY: latched values must win.
    @(negedge clk);
    a_wr = 1'b1; a_addr = 28'h0000400; a_wdata = DAL;
    @(posedge clk); #1;
    a_addr = 28'h0000007; a_wdata = DXX;
    lat = 1;
    while (!a_ready && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    a_wr = 1'b0;
    check("alias latency", 128'(lat), 128'(4));
    check("alias rdata",   a_rdata,   DAL);
    check("alias wr_cnt",  128'(a_wrc), 128'(6));
    repeat (2) @(posedge clk);
    #1;
    run_txn("alias rd0", 1'b1, 1'b0, 28'h0000000, DXX, lat);
    check("alias rd0 rdata", a_rdata, DAL);
    run_txn("alias rd7", 1'b1, 1'b0, 28'h0000007, DXX, lat);
    check("alias rd7 rdata", a_rdata, D77);
    check("alias rd_cnt", 128'(a_rdc), 128'(4));

    // Reset during BUSY of a write: outputs clear at once and the write never lands.
    @(negedge clk);
    a_wr = 1'b1; a_addr = 28'h0000003; a_wdata = D55;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort ready",  128'(a_ready), 128'(0));
    check("abort rdata",  a_rdata,       128'(0));
    check("abort rd_cnt", 128'(a_rdc),   128'(0));
    check("abort wr_cnt", 128'(a_wrc),   128'(0));
    a_wr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    highs = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (a_ready) highs++;
    end
    check("abort no pulse", 128'(highs), 128'(0));
    run_txn("abort rd3", 1'b1, 1'b0, 28'h0000003, DXX, lat);
    check("abort rd3 rdata", a_rdata, D11);
    check("abort rd3 rd_cnt", 128'(a_rdc), 128'(1));
    check("abort rd3 wr_cnt", 128'(a_wrc), 128'(0));

    // LATENCY=1 with mem_read held: pulses on edges 1 and 4, COOL and IDLE in between.
    pat = 8'b0000_1001;
    @(negedge clk);
    b_rd = 1'b1; b_addr = 28'h0000000;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("held edge%0d ready", i + 1), 128'(b_ready), 128'(pat[i]));
      if (i == 3) b_rd = 1'b0;
    end
    check("held rd_cnt", 128'(b_rdc), 128'(2));
    check("held wr_cnt", 128'(b_wrc), 128'(0));

    // Preload the read counter near the top, then three reads must saturate at 0xFFFF.
    @(negedge clk);
    force dut_b.rd_count_q = 16'hFFFD;
    #1 release dut_b.rd_count_q;
    b_rd = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 1) check("sat first", 128'(b_rdc), 128'(16'hFFFE));
      if (i == 4) check("sat second", 128'(b_rdc), 128'(16'hFFFF));
      if (i == 7) begin
        check("sat third", 128'(b_rdc), 128'(16'hFFFF));
        check("sat third ready", 128'(b_ready), 128'(1));
        b_rd = 1'b0;
      end
    end
    check("sat hold", 128'(b_rdc), 128'(16'hFFFF));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
